// File: rtl/dma_pkg.sv
// dma_pkg: register map, control/status bit positions and copy-FSM states shared by dma_copy.
package dma_pkg;
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;
  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_CLR_DONE = 2;
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_ABORTED  = 2;
  typedef enum logic [1:0] {IDLE, RD, WR} state_e;
endpackage

// File: rtl/dma_regs.sv
// dma_regs: CPU responder handshake, SRC/DST/LEN register file and CTRL/STAT decode.
module dma_regs
  import dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel_i,
  input  logic [3:0]       addr_i,
  input  logic [3:0]       wstrb_i,
  input  logic [31:0]      di_i,
  output logic [31:0]      do_o,
  output logic             ready_o,
  input  logic             busy_i,
  input  logic             adv_i,
  input  logic             fin_done_i,
  input  logic             fin_abort_i,
  output logic             start_o,
  output logic             abort_o,
  output logic [31:0]      src_o,
  output logic [31:0]      dst_o,
  output logic [LEN_W-1:0] len_o,
  output logic             done_o
);
  logic ready_q, ready_d, done_q, done_d, aborted_q, aborted_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, stat, rdata;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0] sel_reg;
  logic we, we_cfg, we_ctl, zero_start, clr, unused_addr;
  assign unused_addr = ^addr_i[1:0];
  assign sel_reg = addr_i[3:2];
  assign we = ready_q & sel_i & |wstrb_i;
  assign we_cfg = we & ~busy_i;
  assign we_ctl = we & (sel_reg == REG_CTRL);
  // START and ABORT are mutually exclusive by BUSY, so a combined write resolves itself
  assign start_o = we_ctl & di_i[CTRL_START] & ~busy_i & (len_q != '0);
  assign zero_start = we_ctl & di_i[CTRL_START] & ~busy_i & (len_q == '0);
  assign abort_o = we_ctl & di_i[CTRL_ABORT] & busy_i;
  assign clr = we_ctl & di_i[CTRL_CLR_DONE];
  always_comb begin
    ready_d = sel_i & ~ready_q;
    src_d = adv_i ? src_q + 32'd4 : (we_cfg && sel_reg == REG_SRC) ? {di_i[31:2], 2'b00} : src_q;
    dst_d = adv_i ? dst_q + 32'd4 : (we_cfg && sel_reg == REG_DST) ? {di_i[31:2], 2'b00} : dst_q;
    len_d = adv_i ? len_q - LEN_W'(1) : (we_cfg && sel_reg == REG_LEN) ? di_i[LEN_W-1:0] : len_q;
    done_d = fin_done_i | zero_start | (done_q & ~clr & ~start_o);
    aborted_d = fin_abort_i | (aborted_q & ~clr & ~start_o & ~zero_start);
  end
  always_comb begin
    stat = {16'(len_q), 16'h0000};
    stat[STAT_BUSY] = busy_i;
    stat[STAT_DONE] = done_q;
    stat[STAT_ABORTED] = aborted_q;
    rdata = sel_reg == REG_SRC ? src_q : sel_reg == REG_DST ? dst_q :
            sel_reg == REG_LEN ? 32'(len_q) : stat;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      done_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      done_q <= done_d;
      aborted_q <= aborted_d;
    end
  end
  assign do_o = ready_q ? rdata : '0;
  assign ready_o = ready_q;
  assign src_o = src_q;
  assign dst_o = dst_q;
  assign len_o = len_q;
  assign done_o = done_q;
endmodule

// File: rtl/dma_copy.sv
// dma_copy: word-granular memory-to-memory copy engine; copy FSM and master port around dma_regs.
module dma_copy
  import dma_pkg::*;
#(
  parameter int         LEN_W    = 16,
  parameter logic [3:0] WSTRB_WR = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_sel,
  input  logic [3:0]  dma_addr,
  input  logic [3:0]  dma_wstrb,
  input  logic [31:0] dma_di,
  output logic [31:0] dma_do,
  output logic        dma_ready,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        dma_irq
);
  state_e state_q, state_d;
  logic m_valid_q, m_valid_d, abort_q, abort_d;
  logic [31:0] buf_q, buf_d, src, dst;
  logic [LEN_W-1:0] len;
  logic start, abort_req, done, hs, ab, last, stop, busy, adv, fin_done, fin_abort;
  dma_regs #(.LEN_W(LEN_W)) u_regs (
    .clk(clk), .reset(reset), .sel_i(dma_sel), .addr_i(dma_addr), .wstrb_i(dma_wstrb),
    .di_i(dma_di), .do_o(dma_do), .ready_o(dma_ready), .busy_i(busy), .adv_i(adv),
    .fin_done_i(fin_done), .fin_abort_i(fin_abort), .start_o(start), .abort_o(abort_req),
    .src_o(src), .dst_o(dst), .len_o(len), .done_o(done)
  );
  assign hs = m_valid_q & m_ready;
  assign ab = abort_q | abort_req;
  assign last = len == LEN_W'(1);
  // an abort lands once no transaction is outstanding: at a handshake or in the gap cycle
  assign stop = ab & (hs | ~m_valid_q);
  assign busy = state_q != IDLE;
  assign adv = state_q == WR && hs;
  assign fin_done = adv & last & ~ab;
  assign fin_abort = busy & stop;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      m_valid_q <= 1'b0;
      abort_q <= 1'b0;
      buf_q <= '0;
    end else begin
      state_q <= state_d;
      m_valid_q <= m_valid_d;
      abort_q <= abort_d;
      buf_q <= buf_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (start ? RD : IDLE) : stop ? IDLE :
              hs ? (state_q == RD ? WR : last ? IDLE : RD) : state_q;
    m_valid_d = state_d != IDLE && !hs;
    abort_d = state_d != IDLE && ab;
    buf_d = state_q == RD && hs ? m_rdata : buf_q;
  end
  always_comb begin
    m_valid = m_valid_q;
    m_addr = !m_valid_q ? '0 : state_q == WR ? dst : src;
    m_wdata = m_valid_q && state_q == WR ? buf_q : '0;
    m_wstrb = m_valid_q && state_q == WR ? WSTRB_WR : 4'h0;
    dma_irq = done;
  end
endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: register table, directed corner sequences and random copies checked against a transaction-list model.
module tb_dma_copy;
  import dma_pkg::*;
  logic clk = 1'b0, reset = 1'b1, dma_sel = 1'b0, m_ready = 1'b0;
  logic [3:0] dma_addr = '0, dma_wstrb = '0, m_wstrb;
  logic [31:0] dma_di = '0, m_rdata = '0, dma_do, m_addr, m_wdata;
  logic dma_ready, m_valid, dma_irq;
  int nchk = 0, nerr = 0;
  typedef struct {logic wr; logic [31:0] a; logic [31:0] d;} txn_t;
  typedef struct {logic [1:0] r; logic [31:0] wd; logic [31:0] exp;} vec_t;
  txn_t log_q[$], exp_q[$];
  vec_t tv[5];
  logic [31:0] mem [logic [31:0]];
  int waits = 0, cnt = 0, cur_w = 0, nvalid = 0, stab_err = 0;
  bit rand_w = 1'b0;
  logic [31:0] h_a, h_d, rv;
  logic [3:0] h_s;
  always #5 clk = ~clk;
  dma_copy dut (
    .clk(clk), .reset(reset), .dma_sel(dma_sel), .dma_addr(dma_addr), .dma_wstrb(dma_wstrb),
    .dma_di(dma_di), .dma_do(dma_do), .dma_ready(dma_ready), .m_valid(m_valid), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready), .dma_irq(dma_irq)
  );
  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // memory responder: fixed or random wait states, logs every completed transaction
  initial forever begin
    @(posedge clk); #1;
    if (m_valid === 1'b1) nvalid++;
    if (reset) begin
      m_ready = 1'b0; cnt = 0;
    end else if (m_ready) begin
      m_ready = 1'b0; m_rdata = '0;
      chk("valid_drop_after_ready", {31'b0, m_valid}, 32'd0);
    end else if (m_valid === 1'b1) begin
      if (cnt == 0) begin
        h_a = m_addr; h_d = m_wdata; h_s = m_wstrb;
        cur_w = rand_w ? int'($urandom_range(0, 3)) : waits;
        if (m_wstrb != 4'h0 && m_wstrb != 4'hF) stab_err++;
      end else if (m_addr !== h_a || m_wdata !== h_d || m_wstrb !== h_s) stab_err++;
      if (cnt < cur_w) cnt++;
      else begin
        m_ready = 1'b1; cnt = 0;
        if (m_wstrb == 4'hF) begin
          mem[m_addr] = m_wdata;
          log_q.push_back('{1'b1, m_addr, m_wdata});
        end else begin
          m_rdata = rd(m_addr);
          log_q.push_back('{1'b0, m_addr, m_rdata});
        end
      end
    end else begin
      if (cnt != 0) stab_err++;
      cnt = 0;
    end
  end
  task automatic reg_wr(input logic [1:0] r, input logic [31:0] d);
    dma_sel = 1'b1; dma_addr = {r, 2'b00}; dma_wstrb = 4'hF; dma_di = d;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dma_sel = 1'b0; dma_wstrb = '0; dma_di = '0;
  endtask
  task automatic reg_rd(input logic [1:0] r, output logic [31:0] d);
    dma_sel = 1'b1; dma_addr = {r, 2'b00}; dma_wstrb = '0;
    @(posedge clk); #1;
    d = dma_ready ? dma_do : 32'hBAD0_BAD0;
    @(posedge clk); #1;
    dma_sel = 1'b0;
  endtask
  task automatic rd_chk(input string nm, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] d;
    reg_rd(r, d);
    chk(nm, d, exp);
  endtask
  task automatic wait_irq(input int bound);
    for (int k = 0; k < bound && dma_irq !== 1'b1; k++) begin @(posedge clk); #1; end
    chk("done_timeout", {31'b0, dma_irq}, 32'd1);
  endtask
  task automatic wait_idle(input int bound);
    logic [31:0] s;
    s = 32'd1;
    for (int k = 0; k < bound && s[STAT_BUSY]; k++) reg_rd(REG_CTRL, s);
    chk("idle_timeout", {31'b0, s[STAT_BUSY]}, 32'd0);
  endtask
  // model: a copy of n words is n read/write pairs walking both addresses upward mod 2^32
  task automatic predict(input logic [31:0] src, input logic [31:0] dst, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{1'b0, src + 32'(4 * i), rd(src + 32'(4 * i))});
      exp_q.push_back('{1'b1, dst + 32'(4 * i), rd(src + 32'(4 * i))});
    end
  endtask
  task automatic check_log();
    chk("txn_count", log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("txn%0d_kind", i), {31'b0, log_q[i].wr}, {31'b0, exp_q[i].wr});
      chk($sformatf("txn%0d_addr", i), log_q[i].a, exp_q[i].a);
      chk($sformatf("txn%0d_data", i), log_q[i].d, exp_q[i].d);
    end
    chk("bus_stability", stab_err, 32'd0);
  endtask
  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int n);
    predict(src, dst, n);
    log_q.delete(); stab_err = 0;
    reg_wr(REG_SRC, src); reg_wr(REG_DST, dst); reg_wr(REG_LEN, n);
    reg_wr(REG_CTRL, 32'h1);
    wait_irq(n * 40 + 50);
    check_log();
    for (int i = 0; i < n; i++) chk($sformatf("copied%0d", i), rd(dst + 32'(4 * i)), exp_q[2 * i].d);
    rd_chk("src_final", REG_SRC, src + 32'(4 * n));
    rd_chk("dst_final", REG_DST, dst + 32'(4 * n));
    rd_chk("stat_done", REG_CTRL, 32'h0000_0002);
  endtask
  initial begin
    tv[0] = '{REG_SRC, 32'h1234_5677, 32'h1234_5674};
    tv[1] = '{REG_DST, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    tv[2] = '{REG_LEN, 32'hABCD_1234, 32'h0000_1234};
    tv[3] = '{REG_CTRL, 32'h0000_0000, 32'h1234_0000};
    tv[4] = '{REG_SRC, 32'h0000_0003, 32'h0000_0000};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_dma_ready", {31'b0, dma_ready}, 32'd0);
    chk("rst_dma_do", dma_do, 32'd0);
    chk("rst_irq", {31'b0, dma_irq}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    reset = 1'b0;
    for (int r = 0; r < 4; r++) rd_chk($sformatf("rst_reg%0d", r), 2'(r), 32'd0);
    for (int i = 0; i < 5; i++) begin
      reg_wr(tv[i].r, tv[i].wd);
      reg_rd(tv[i].r, rv);
      chk($sformatf("table%0d", i), rv, tv[i].exp);
    end
    // responder pulse: sel held two cycles gives one ready cycle with data, then zero
    dma_sel = 1'b1; dma_addr = {REG_LEN, 2'b00}; dma_wstrb = '0;
    @(posedge clk); #1;
    chk("hs_ready", {31'b0, dma_ready}, 32'd1);
    chk("hs_do", dma_do, 32'h0000_1234);
    @(posedge clk); #1;
    chk("hs_ready_drop", {31'b0, dma_ready}, 32'd0);
    chk("hs_do_zero", dma_do, 32'd0);
    dma_sel = 1'b0;
    @(posedge clk); #1;
    waits = 0;
    run_xfer(32'h100, 32'h200, 3);
    waits = 3;
    run_xfer(32'h100, 32'h200, 3);
    waits = 0;
    reg_wr(REG_LEN, 32'd0);
    reg_wr(REG_CTRL, 32'h4);
    rd_chk("len0_pre", REG_CTRL, 32'd0);
    nvalid = 0;
    reg_wr(REG_CTRL, 32'h1);
    chk("len0_irq", {31'b0, dma_irq}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    rd_chk("len0_stat", REG_CTRL, 32'h0000_0002);
    chk("len0_no_bus", nvalid, 32'd0);
    reg_wr(REG_CTRL, 32'h4);
    rd_chk("len0_clr", REG_CTRL, 32'd0);
    chk("len0_irq_clr", {31'b0, dma_irq}, 32'd0);
    waits = 10;
    predict(32'h400, 32'h500, 8);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    log_q.delete(); stab_err = 0;
    reg_wr(REG_SRC, 32'h400); reg_wr(REG_DST, 32'h500); reg_wr(REG_LEN, 32'd8);
    reg_wr(REG_CTRL, 32'h1);
    for (int k = 0; k < 400 && !(log_q.size() == 4 && m_valid === 1'b1 && m_wstrb == 4'h0); k++) begin
      @(posedge clk); #1;
    end
    chk("abort_third_read_seen", log_q.size(), 32'd4);
    reg_wr(REG_SRC, 32'hDEAD_0000);
    reg_wr(REG_CTRL, 32'h3);
    wait_idle(200);
    check_log();
    rd_chk("abort_stat", REG_CTRL, 32'h0006_0004);
    rd_chk("abort_src", REG_SRC, 32'h408);
    rd_chk("abort_dst", REG_DST, 32'h508);
    chk("abort_irq", {31'b0, dma_irq}, 32'd0);
    reg_wr(REG_CTRL, 32'h2);
    rd_chk("abort_idle_noop", REG_CTRL, 32'h0006_0004);
    reg_wr(REG_CTRL, 32'h4);
    rd_chk("abort_clr", REG_CTRL, 32'h0006_0000);
    waits = 0;
    run_xfer(32'hFFFF_FFFC, 32'h600, 2);
    rand_w = 1'b1;
    for (int t = 0; t < 5; t++)
      run_xfer(32'h1000 + ($urandom_range(0, 255) << 2), 32'h8000 + ($urandom_range(0, 255) << 2),
               int'($urandom_range(1, 12)));
    rand_w = 1'b0;
    waits = 5;
    reg_wr(REG_SRC, 32'h700); reg_wr(REG_DST, 32'h800); reg_wr(REG_LEN, 32'd4);
    reg_wr(REG_CTRL, 32'h1);
    for (int k = 0; k < 200 && !(m_valid === 1'b1 && m_wstrb == 4'hF); k++) begin
      @(posedge clk); #1;
    end
    chk("rst_wr_seen", {28'b0, m_wstrb}, 32'hF);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_valid", {31'b0, m_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int r = 0; r < 4; r++) rd_chk($sformatf("post_rst_reg%0d", r), 2'(r), 32'd0);
    chk("post_rst_irq", {31'b0, dma_irq}, 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
